// File: rtl/dpram_fifo_ctrl.sv
// Valid/ready FIFO controller in front of an external dual-port RAM with a
// registered 1-cycle read; presents a first-word-fall-through output stream.
module dpram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
    logic                  out_valid_q, out_valid_d;

    logic push;
    logic pop;
    logic fetch;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        in_ready = rst_n && !flush && (ram_count_q < DEPTH_CNT);
        push     = in_valid && in_ready;
        pop      = out_valid_q && out_ready;
        // Registered count excludes this cycle's push, so a slot is never
        // read in the cycle it is written.
        fetch    = !flush && (ram_count_q != '0) && (!out_valid_q || out_ready);
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        out_valid_d = out_valid_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ram_count_d = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (fetch) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end

            case ({push, fetch})
                2'b10:   ram_count_d = ram_count_q + 1'b1;
                2'b01:   ram_count_d = ram_count_q - 1'b1;
                default: ram_count_d = ram_count_q;
            endcase

            // The fetched word lands in the output stage next cycle.
            if (fetch) begin
                out_valid_d = 1'b1;
            end else if (pop) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        mem_wr_en   = push;
        mem_wr_addr = wr_ptr_q;
        mem_wr_data = in_data;
        mem_rd_en   = fetch;
        mem_rd_addr = rd_ptr_q;
        out_valid   = out_valid_q;
        out_data    = mem_rd_data;
        level       = ram_count_q + (ADDR_WIDTH + 1)'(out_valid_q);
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: DEPTH=16 and DEPTH=12 instances share one
// directed stimulus; each has its own RAM and queue-based reference model.
module tb_dpram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       in_ready_w    [2];
    logic       out_valid_w   [2];
    logic       mem_wr_en_w   [2];
    logic       mem_rd_en_w   [2];
    logic [7:0] out_data_w    [2];
    logic [7:0] mem_wr_data_w [2];
    logic [7:0] mem_rd_data_w [2];
    logic [3:0] mem_wr_addr_w [2];
    logic [3:0] mem_rd_addr_w [2];
    logic [4:0] level_w       [2];

    int n_checks = 0;
    int n_fail   = 0;
    int max_wr   [2];
    int wr_wraps [2];
    int rd_wraps [2];

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int D = (g == 0) ? 16 : 12;

        logic [7:0] ram [16];
        logic [7:0] rd_q;
        logic [7:0] q [$];
        logic [7:0] head;
        bit         ov;
        int         nwr;
        int         nrd;

        dpram_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(D)) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (flush),
            .in_valid    (in_valid),
            .in_ready    (in_ready_w[g]),
            .in_data     (in_data),
            .out_valid   (out_valid_w[g]),
            .out_ready   (out_ready),
            .out_data    (out_data_w[g]),
            .level       (level_w[g]),
            .mem_wr_en   (mem_wr_en_w[g]),
            .mem_wr_addr (mem_wr_addr_w[g]),
            .mem_wr_data (mem_wr_data_w[g]),
            .mem_rd_en   (mem_rd_en_w[g]),
            .mem_rd_addr (mem_rd_addr_w[g]),
            .mem_rd_data (mem_rd_data_w[g])
        );

        // Dual-port RAM: registered read, rd_data held while rd_en is low.
        assign mem_rd_data_w[g] = rd_q;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) rd_q <= 8'h00;
            else if (mem_rd_en_w[g]) rd_q <= ram[mem_rd_addr_w[g]];
        end
        always @(posedge clk) begin
            if (mem_wr_en_w[g]) ram[mem_wr_addr_w[g]] <= mem_wr_data_w[g];
        end

        function automatic bit m_in_ready();
            return rst_n && !flush && (q.size() < D);
        endfunction

        function automatic bit m_fetch();
            return rst_n && !flush && (q.size() != 0) && (!ov || out_ready);
        endfunction

        // Reference model: words still in RAM are a queue, the output stage a
        // single held word; addresses are the event counts modulo D.
        initial begin
            head = 8'h00; ov = 0; nwr = 0; nrd = 0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n || flush) begin
                    q.delete(); ov = 0; nwr = 0; nrd = 0;
                end else begin
                    bit p, f;
                    p = in_valid && m_in_ready();
                    f = m_fetch();
                    if (f) begin
                        head = q.pop_front(); ov = 1; nrd++;
                    end else if (ov && out_ready) begin
                        ov = 0;
                    end
                    if (p) begin
                        q.push_back(in_data); nwr++;
                    end
                end
            end
        end

        initial begin
            int last_wr, last_rd;
            string s;
            last_wr = -1; last_rd = -1; max_wr[g] = 0; wr_wraps[g] = 0; rd_wraps[g] = 0;
            s = $sformatf("d%0d.", D);
            forever begin
                @(negedge clk);
                chk({s, "in_ready"},    int'(in_ready_w[g]),    int'(m_in_ready()));
                chk({s, "mem_wr_en"},   int'(mem_wr_en_w[g]),   int'(in_valid && m_in_ready()));
                chk({s, "mem_wr_addr"}, int'(mem_wr_addr_w[g]), nwr % D);
                chk({s, "mem_rd_en"},   int'(mem_rd_en_w[g]),   int'(m_fetch()));
                chk({s, "mem_rd_addr"}, int'(mem_rd_addr_w[g]), nrd % D);
                chk({s, "out_valid"},   int'(out_valid_w[g]),   int'(ov));
                chk({s, "level"},       int'(level_w[g]),       q.size() + int'(ov));
                if (mem_wr_en_w[g]) chk({s, "mem_wr_data"}, int'(mem_wr_data_w[g]), int'(in_data));
                if (ov) chk({s, "out_data"}, int'(out_data_w[g]), int'(head));
                if (mem_wr_en_w[g]) begin
                    if (last_wr == D - 1 && mem_wr_addr_w[g] == 0) wr_wraps[g]++;
                    last_wr = mem_wr_addr_w[g];
                    if (mem_wr_addr_w[g] > max_wr[g]) max_wr[g] = mem_wr_addr_w[g];
                end
                if (mem_rd_en_w[g]) begin
                    if (last_rd == D - 1 && mem_rd_addr_w[g] == 0) rd_wraps[g]++;
                    last_rd = mem_rd_addr_w[g];
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int data, accepts, n, first, last;
        int got [64];

        // Reset with a producer already presenting a word.
        in_valid = 1'b1; in_data = 8'h77;
        repeat (3) @(negedge clk);
        chk("rst.in_ready",  int'(in_ready_w[0]), 0);
        chk("rst.mem_wr_en", int'(mem_wr_en_w[0]), 0);
        chk("rst.mem_rd_en", int'(mem_rd_en_w[0]), 0);
        chk("rst.out_valid", int'(out_valid_w[0]), 0);
        chk("rst.level",     int'(level_w[0]), 0);
        chk("rst.wr_addr",   int'(mem_wr_addr_w[0]), 0);
        chk("rst.rd_addr",   int'(mem_rd_addr_w[0]), 0);
        chk("rst.out_data",  int'(out_data_w[0]), 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;

        // Single word: push at cycle 0, rd_en at 1, out_valid at 2.
        next_cycle();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        @(negedge clk);
        chk("single.in_ready", int'(in_ready_w[0]), 1);
        chk("single.wr_en",    int'(mem_wr_en_w[0]), 1);
        chk("single.wr_addr",  int'(mem_wr_addr_w[0]), 0);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("single.rd_en_c1",     int'(mem_rd_en_w[0]), 1);
        chk("single.out_valid_c1", int'(out_valid_w[0]), 0);
        next_cycle();
        @(negedge clk);
        chk("single.out_valid_c2", int'(out_valid_w[0]), 1);
        chk("single.out_data_c2",  int'(out_data_w[0]), 8'hA5);
        chk("single.level_c2",     int'(level_w[0]), 1);
        next_cycle();
        @(negedge clk);
        chk("single.out_valid_c3", int'(out_valid_w[0]), 0);

        // Fill to full with the consumer stalled.
        next_cycle();
        out_ready = 1'b0; data = 1; accepts = 0;
        repeat (24) begin
            in_valid = (data <= 8'h12); in_data = 8'(data);
            @(negedge clk);
            if (in_valid && in_ready_w[0]) begin accepts++; data++; end
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full.accepts",  accepts, 17);
        chk("full.level",    int'(level_w[0]), 17);
        chk("full.in_ready", int'(in_ready_w[0]), 0);
        chk("full.out_data", int'(out_data_w[0]), 8'h01);

        // Drain after full.
        next_cycle();
        out_ready = 1'b1; n = 0; first = -1; last = -1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 0) chk("drain.in_ready_still_low", int'(in_ready_w[0]), 0);
            if (c == 1) chk("drain.in_ready_reopens", int'(in_ready_w[0]), 1);
            if (out_valid_w[0]) begin
                if (first < 0) first = c;
                last = c;
                got[n] = int'(out_data_w[0]);
                n++;
            end
            next_cycle();
        end
        chk("drain.count", n, 17);
        chk("drain.span",  last - first, 16);
        for (int i = 0; i < 17; i++) chk($sformatf("drain.word%0d", i), got[i], i + 1);
        @(negedge clk);
        chk("drain.level", int'(level_w[0]), 0);
        chk("drain.out_valid", int'(out_valid_w[0]), 0);

        // Streaming 40 words through both instances.
        next_cycle();
        data = 8'h40; n = 0;
        for (int c = 0; c < 50; c++) begin
            in_valid = (data < 8'h68); in_data = 8'(data);
            @(negedge clk);
            if (in_valid && in_ready_w[0]) data++;
            if (out_valid_w[0]) begin got[n] = int'(out_data_w[0]); n++; end
            next_cycle();
        end
        in_valid = 1'b0;
        chk("stream.count", n, 40);
        for (int i = 0; i < 40; i += 7) chk($sformatf("stream.word%0d", i), got[i], 8'h40 + i);
        chk("stream.last_word", got[39], 8'h67);
        chk("wrap16.max_wr_addr", max_wr[0], 15);
        chk("wrap12.max_wr_addr", max_wr[1], 11);
        chk("wrap16.wr_seen", int'(wr_wraps[0] > 0), 1);
        chk("wrap12.wr_seen", int'(wr_wraps[1] > 0), 1);
        chk("wrap16.rd_seen", int'(rd_wraps[0] > 0), 1);
        chk("wrap12.rd_seen", int'(rd_wraps[1] > 0), 1);

        // Flush with five words held.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h21 + i);
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush.level_before", int'(level_w[0]), 5);
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        chk("flush.in_ready_during", int'(in_ready_w[0]), 0);
        chk("flush.rd_en_during",    int'(mem_rd_en_w[0]), 0);
        next_cycle();
        flush = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
        @(negedge clk);
        chk("flush.out_valid_after", int'(out_valid_w[0]), 0);
        chk("flush.level_after",     int'(level_w[0]), 0);
        chk("flush.in_ready_after",  int'(in_ready_w[0]), 1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush.push_c1_out_valid", int'(out_valid_w[0]), 0);
        next_cycle();
        @(negedge clk);
        chk("flush.push_c2_out_valid", int'(out_valid_w[0]), 1);
        chk("flush.push_c2_out_data",  int'(out_data_w[0]), 8'h3C);
        chk("flush.push_c2_level",     int'(level_w[0]), 1);
        next_cycle();
        out_ready = 1'b1;
        next_cycle();

        // Asynchronous reset in the middle of traffic.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h90 + i);
            next_cycle();
        end
        in_data = 8'hC7;
        chk("areset.level_before", int'(level_w[0]), 6);
        #1 rst_n = 1'b0;
        #1;
        chk("areset.out_valid", int'(out_valid_w[0]), 0);
        chk("areset.level",     int'(level_w[0]), 0);
        chk("areset.in_ready",  int'(in_ready_w[0]), 0);
        chk("areset.wr_en",     int'(mem_wr_en_w[0]), 0);
        chk("areset.rd_en",     int'(mem_rd_en_w[0]), 0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("areset.first_cycle_out_valid", int'(out_valid_w[0]), 0);
        chk("areset.first_cycle_in_ready",  int'(in_ready_w[0]), 1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("areset.c1_out_valid", int'(out_valid_w[0]), 0);
        next_cycle();
        @(negedge clk);
        chk("areset.c2_out_valid", int'(out_valid_w[0]), 1);
        chk("areset.c2_out_data",  int'(out_data_w[0]), 8'hC7);
        next_cycle();
        out_ready = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("end.level", int'(level_w[0]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
